zjh_slice_adder: RTL and testbench



---
 rtl/zjh_slice_adder.sv | 131 +++++++++++++
 tb/tb_zjh_slice_adder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/zjh_slice_adder.sv
// Multi-cycle adder/subtractor: adds WIDTH-bit operands SLICE bits per clock,
// holding the ripple carry in a register between slices, with valid/ready on both sides.
module zjh_slice_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [KW-1:0]    k_q, k_d;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE:0]   sum_ext;
    logic             msb_cin;

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
        end
    end

    // One SLICE-bit add per cycle; the carry into the slice MSB is recovered from the sum bit.
    always_comb begin
        a_sl    = a_q[k_q*SLICE +: SLICE];
        b_sl    = b_q[k_q*SLICE +: SLICE];
        sum_ext = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
        msb_cin = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ sum_ext[SLICE-1];
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (k_q == KW'(N - 1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin;
                    s_d     = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    k_d     = '0;
                end
            end
            RUN: begin
                s_d[k_q*SLICE +: SLICE] = sum_ext[SLICE-1:0];
                carry_d                 = sum_ext[SLICE];
                if (k_q == KW'(N - 1)) begin
                    cout_d = sum_ext[SLICE];
                    ovf_d  = msb_cin ^ sum_ext[SLICE];
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs; in_ready is forced low while reset is held
    always_comb begin
        in_ready  = (state_q == IDLE) && rst_n;
        out_valid = (state_q == DONE);
        s         = s_q;
        cout      = cout_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_zjh_slice_adder.sv
// Bench for zjh_slice_adder: directed cases on the 16/4 build, then random sweeps on
// 8/8, 8/1 and 32/4 builds, all scored through a queue of expected results.
module tb_zjh_slice_adder;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  iv;
    logic [31:0] a_tb, b_tb;
    logic        cin_tb, sub_tb, out_ready_tb;
    logic [3:0]  in_ready_w, out_valid_w, cout_w, ovf_w;
    logic [15:0] s0;
    logic [7:0]  s1, s2;
    logic [31:0] s3;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t last_e;

    always #5 clk = ~clk;

    zjh_slice_adder #(.WIDTH(16), .SLICE(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(in_ready_w[0]),
        .a(a_tb[15:0]), .b(b_tb[15:0]), .cin(cin_tb), .sub(sub_tb),
        .out_valid(out_valid_w[0]), .out_ready(out_ready_tb),
        .s(s0), .cout(cout_w[0]), .ovf(ovf_w[0]));

    zjh_slice_adder #(.WIDTH(8), .SLICE(8)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(in_ready_w[1]),
        .a(a_tb[7:0]), .b(b_tb[7:0]), .cin(cin_tb), .sub(sub_tb),
        .out_valid(out_valid_w[1]), .out_ready(out_ready_tb),
        .s(s1), .cout(cout_w[1]), .ovf(ovf_w[1]));

    zjh_slice_adder #(.WIDTH(8), .SLICE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(in_ready_w[2]),
        .a(a_tb[7:0]), .b(b_tb[7:0]), .cin(cin_tb), .sub(sub_tb),
        .out_valid(out_valid_w[2]), .out_ready(out_ready_tb),
        .s(s2), .cout(cout_w[2]), .ovf(ovf_w[2]));

    zjh_slice_adder #(.WIDTH(32), .SLICE(4)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(in_ready_w[3]),
        .a(a_tb), .b(b_tb), .cin(cin_tb), .sub(sub_tb),
        .out_valid(out_valid_w[3]), .out_ready(out_ready_tb),
        .s(s3), .cout(cout_w[3]), .ovf(ovf_w[3]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic get_s(input int inst, output logic [31:0] so);
        case (inst)
            0:       so = {16'h0, s0};
            1:       so = {24'h0, s1};
            2:       so = {24'h0, s2};
            default: so = s3;
        endcase
    endtask

    function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic ci, input logic sb);
        exp_t        e;
        logic [63:0] mask, am, bm, full;
        mask   = (64'd1 << w) - 64'd1;
        am     = {32'h0, av} & mask;
        bm     = (sb ? ~{32'h0, bv} : {32'h0, bv}) & mask;
        full   = am + bm + {63'h0, ci};
        e.s    = 32'(full & mask);
        e.cout = full[w];
        e.ovf  = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
        return e;
    endfunction

    // Accept one operand set, wait (bounded) for out_valid, then score against the queue head.
    task automatic run_op(input int inst, input int n, input logic [31:0] av,
                          input logic [31:0] bv, input logic ci, input logic sb, input exp_t e);
        int          lat;
        logic        seen;
        logic [31:0] so;
        exp_t        ge;
        a_tb = av; b_tb = bv; cin_tb = ci; sub_tb = sb;
        check("in_ready_before_accept", {63'h0, in_ready_w[inst]}, 64'd1);
        iv[inst] = 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        iv[inst] = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < n + 4) begin
            @(posedge clk); #1;
            lat++;
            seen = out_valid_w[inst];
        end
        check("latency", 64'(lat), 64'(n));
        if (sb_q.size() > 0) begin
            ge     = sb_q.pop_front();
            last_e = ge;
            get_s(inst, so);
            check("s", {32'h0, so}, {32'h0, ge.s});
            check("cout", {63'h0, cout_w[inst]}, {63'h0, ge.cout});
            check("ovf", {63'h0, ovf_w[inst]}, {63'h0, ge.ovf});
        end
        if (out_ready_tb) begin
            @(posedge clk); #1;
            check("out_valid_one_cycle", {63'h0, out_valid_w[inst]}, 64'd0);
            check("in_ready_after_hs", {63'h0, in_ready_w[inst]}, 64'd1);
        end
    endtask

    task automatic sweep(input int inst, input int w, input int n);
        logic [31:0] av, bv;
        logic        ci, sb;
        for (int i = 0; i < 1000; i++) begin
            av = $urandom;
            bv = $urandom;
            ci = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            run_op(inst, n, av, bv, ci, sb, model(w, av, bv, ci, sb));
        end
    endtask

    initial begin
        logic [31:0] so;
        exp_t        e;
        iv = 4'b0; a_tb = '0; b_tb = '0; cin_tb = 0; sub_tb = 0; out_ready_tb = 1;
        rst_n = 1'b0;
        #3;
        check("rst_in_ready_low", {60'h0, in_ready_w}, 64'h0);
        check("rst_out_valid", {60'h0, out_valid_w}, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", {60'h0, in_ready_w}, 64'hF);
        check("post_rst_s", {32'h0, s3}, 64'h0);

        // Directed cases on the 16/4 build
        e = '{s: 32'h0000, cout: 1'b1, ovf: 1'b0};
        run_op(0, 4, 32'hFFFF, 32'h0001, 1'b0, 1'b0, e);
        e = '{s: 32'hFFFE, cout: 1'b0, ovf: 1'b0};
        run_op(0, 4, 32'h0005, 32'h0007, 1'b1, 1'b1, e);
        e = '{s: 32'h0002, cout: 1'b1, ovf: 1'b0};
        run_op(0, 4, 32'h0007, 32'h0005, 1'b1, 1'b1, e);
        e = '{s: 32'h8000, cout: 1'b0, ovf: 1'b1};
        run_op(0, 4, 32'h7FFF, 32'h0001, 1'b0, 1'b0, e);
        e = '{s: 32'h0000, cout: 1'b1, ovf: 1'b1};
        run_op(0, 4, 32'h8000, 32'h8000, 1'b0, 1'b0, e);

        // Backpressure: results must hold while in_valid and a wiggle
        out_ready_tb = 1'b0;
        e = '{s: 32'h2468, cout: 1'b0, ovf: 1'b0};
        run_op(0, 4, 32'h1234, 32'h1234, 1'b0, 1'b0, e);
        for (int i = 0; i < 10; i++) begin
            iv[0] = i[0];
            a_tb  = $urandom;
            @(posedge clk); #1;
            check("bp_out_valid", {63'h0, out_valid_w[0]}, 64'd1);
            check("bp_s", {48'h0, s0}, {32'h0, last_e.s});
            check("bp_cout", {63'h0, cout_w[0]}, {63'h0, last_e.cout});
            check("bp_ovf", {63'h0, ovf_w[0]}, {63'h0, last_e.ovf});
            check("bp_in_ready", {63'h0, in_ready_w[0]}, 64'd0);
        end
        iv[0] = 1'b0;
        out_ready_tb = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", {63'h0, in_ready_w[0]}, 64'd1);
        check("bp_release_out_valid", {63'h0, out_valid_w[0]}, 64'd0);

        // Reset in the middle of RUN, with two slices already written
        a_tb = 32'hFFFF; b_tb = 32'h1111; cin_tb = 0; sub_tb = 0;
        iv[0] = 1'b1;
        sb_q.push_back(model(16, 32'hFFFF, 32'h1111, 1'b0, 1'b0));
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("partial_s_k2", {48'h0, s0}, 64'h0010);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_s", {48'h0, s0}, 64'h0);
        check("mid_rst_out_valid", {63'h0, out_valid_w[0]}, 64'd0);
        check("mid_rst_in_ready", {63'h0, in_ready_w[0]}, 64'd0);
        check("mid_rst_cout_ovf", {62'h0, cout_w[0], ovf_w[0]}, 64'd0);
        sb_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        e = '{s: 32'h5555, cout: 1'b0, ovf: 1'b0};
        run_op(0, 4, 32'h1234, 32'h4321, 1'b0, 1'b0, e);

        // Parameter sweeps
        sweep(1, 8, 1);
        sweep(2, 8, 8);
        sweep(3, 32, 8);
        get_s(3, so);
        check("queue_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
